fetch_queue: RTL and testbench

Instruction fetch stage directly downstream of the program counter. Each cycle it presents `prog_ctr` to synchronous instruction memory and captures the returned word with its PC into a 2-entry queue. The queue head is offered to decode over a valid/ready handshake. It back-pressures the PC through `pc_hold` and discards wrong-path words on `flush`.

---
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_queue.sv | 73 +++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-stage signal bundle: PC handoff, instruction-memory port and decode handshake.
// master = fetch queue side, slave = PC stage / memory / decode side.
interface fetch_queue_if #(
  parameter int unsigned D = 8,
  parameter int unsigned W = 9
);
  logic [D-1:0] prog_ctr;
  logic         pc_hold;
  logic         flush;
  logic [D-1:0] imem_addr;
  logic         imem_en;
  logic [W-1:0] imem_data;
  logic [W-1:0] instr;
  logic [D-1:0] instr_pc;
  logic         instr_valid;
  logic         instr_ready;

  modport master (
    input  prog_ctr, flush, imem_data, instr_ready,
    output pc_hold, imem_addr, imem_en, instr, instr_pc, instr_valid
  );

  modport slave (
    output prog_ctr, flush, imem_data, instr_ready,
    input  pc_hold, imem_addr, imem_en, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues prog_ctr to synchronous imem, queues returned words
// with their PC in a 2-entry ring, and offers the head to decode over valid/ready.
module fetch_queue #(
  parameter int unsigned D = 8,
  parameter int unsigned W = 9
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  logic [W-1:0] q_instr [2];
  logic [D-1:0] q_pc    [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         inflight;
  logic [D-1:0] inflight_pc;

  logic         pop;
  logic         issue;
  logic [2:0]   occ;

  // A slot freed by this cycle's pop may be reused by this cycle's issue,
  // which makes instr_ready -> pc_hold/imem_en a combinational path.
  always_comb begin
    pop   = (count != 2'd0) & bus.instr_ready;
    occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue = ~reset & ~bus.flush & (occ < 3'd2);
  end

  assign bus.imem_addr   = bus.prog_ctr;
  assign bus.imem_en     = issue;
  assign bus.pc_hold     = reset | (~bus.flush & ~issue);
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = q_instr[rd_ptr];
  assign bus.instr_pc    = q_pc[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (bus.flush) begin
      // The word returning next cycle belongs to the wrong path; forget it.
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= bus.prog_ctr;
      end
      if (inflight) begin
        q_instr[wr_ptr] <= bus.imem_data;
        q_pc[wr_ptr]    <= inflight_pc;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: PC-stage and imem models, hand-derived
// per-cycle vectors, an in-order PC scoreboard, and an async-reset sequence.
module tb_fetch_queue;
  localparam int unsigned D = 8;
  localparam int unsigned W = 9;

  logic clk;
  logic reset;

  fetch_queue_if #(.D(D), .W(W)) bus ();

  fetch_queue #(.D(D), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [D-1:0] pc;
  logic [D-1:0] sb[$];
  logic         s_valid, s_hold, s_en;
  logic [D-1:0] s_pc;
  logic [W-1:0] s_instr;

  typedef struct {
    logic         rst, rdy, fl;
    logic [D-1:0] tgt;
    logic         valid;
    logic [D-1:0] epc;
    logic         hold, en;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [W-1:0] mem(input logic [D-1:0] a);
    return {a[3] ^ a[0], a ^ 8'h5A};
  endfunction

  function automatic vec_t v(input logic rst, input logic rdy, input logic fl,
                             input logic [D-1:0] tgt, input logic valid,
                             input logic [D-1:0] epc, input logic hold, input logic en);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.fl = fl; r.tgt = tgt;
    r.valid = valid; r.epc = epc; r.hold = hold; r.en = en;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs sampled mid-cycle.
  task automatic step(input logic r, input logic rdy, input logic fl, input logic [D-1:0] tgt);
    logic [D-1:0] e;
    int occ;
    reset           = r;
    bus.instr_ready = rdy;
    bus.flush       = fl;
    #2;
    s_valid = bus.instr_valid;
    s_pc    = bus.instr_pc;
    s_instr = bus.instr;
    s_hold  = bus.pc_hold;
    s_en    = bus.imem_en;
    chk("imem_addr", 32'(bus.imem_addr), 32'(pc));
    occ = int'(dut.count) + int'(dut.inflight);
    chk("occupancy_le_2", 32'(occ <= 2), 32'd1);
    if (r || fl) begin
      sb.delete();
    end else begin
      if (s_valid && rdy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_pop: got word pc 0x%0h expected none (t=%0t)", s_pc, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", 32'(s_pc), 32'(e));
          chk("sb_instr", 32'(s_instr), 32'(mem(e)));
        end
      end
      if (!s_hold) sb.push_back(pc);
    end
    @(posedge clk);
    #1;
    if (s_en) bus.imem_data = mem(pc);
    if (r)             pc = '0;
    else if (fl)       pc = tgt;
    else if (!s_hold)  pc = pc + 1'b1;
    bus.prog_ctr = pc;
  endtask

  initial begin
    reset           = 1'b1;
    pc              = '0;
    bus.prog_ctr    = '0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.imem_data   = '0;
    @(posedge clk);
    #1;

    // Reset release, straight-line fetch from 0.
    tbl.push_back(v(1,1,0,8'h00, 0,8'h00,1,0));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h01,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h02,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h03,0,1));
    // Back-pressure: ready low for 4 cycles while head is 0x00.
    tbl.push_back(v(1,1,0,8'h00, 0,8'h00,1,0));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,0,0,8'h00, 1,8'h00,1,0));
    tbl.push_back(v(0,0,0,8'h00, 1,8'h00,1,0));
    tbl.push_back(v(0,0,0,8'h00, 1,8'h00,1,0));
    tbl.push_back(v(0,0,0,8'h00, 1,8'h00,1,0));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h01,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h02,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h03,0,1));
    // Full queue flushed to 0x40, then flush with pop and word in flight to 0x80.
    tbl.push_back(v(1,1,0,8'h00, 0,8'h00,1,0));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    for (int k = 0; k < 5; k++) tbl.push_back(v(0,1,0,8'h00, 1,8'(k),0,1));
    tbl.push_back(v(0,0,0,8'h00, 1,8'h05,1,0));
    tbl.push_back(v(0,0,1,8'h40, 1,8'h05,0,0));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h40,0,1));
    tbl.push_back(v(0,1,1,8'h80, 1,8'h41,0,0));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h80,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h81,0,1));
    // PC wrap 0xFE -> 0xFF -> 0x00.
    tbl.push_back(v(1,1,0,8'h00, 0,8'h00,1,0));
    tbl.push_back(v(0,1,1,8'hFE, 0,8'h00,0,0));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'hFE,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'hFF,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h00,0,1));
    tbl.push_back(v(0,1,0,8'h00, 1,8'h01,0,1));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].fl, tbl[i].tgt);
      chk($sformatf("vec%0d instr_valid", i), 32'(s_valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d pc_hold", i), 32'(s_hold), 32'(tbl[i].hold));
      chk($sformatf("vec%0d imem_en", i), 32'(s_en), 32'(tbl[i].en));
      if (tbl[i].valid || tbl[i].rst) begin
        chk($sformatf("vec%0d instr_pc", i), 32'(s_pc), 32'(tbl[i].epc));
        chk($sformatf("vec%0d instr", i), 32'(s_instr),
            tbl[i].rst ? 32'd0 : 32'(mem(tbl[i].epc)));
      end
    end

    // Asynchronous reset mid-cycle with the queue full.
    step(1,1,0,8'h00);
    step(0,1,0,8'h00);
    step(0,1,0,8'h00);
    step(0,0,0,8'h00);
    step(0,0,0,8'h00);
    bus.instr_ready = 1'b0;
    #2;
    chk("pre_reset instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("pre_reset count", 32'(dut.count), 32'd2);
    #1 reset = 1'b1;
    #1;
    chk("async_reset instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("async_reset instr_pc", 32'(bus.instr_pc), 32'd0);
    chk("async_reset pc_hold", 32'(bus.pc_hold), 32'd1);
    chk("async_reset imem_en", 32'(bus.imem_en), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    pc = '0;
    bus.prog_ctr = pc;
    step(0,1,0,8'h00);
    chk("restart imem_en", 32'(s_en), 32'd1);
    step(0,1,0,8'h00);
    chk("restart valid_latency", 32'(s_valid), 32'd0);
    step(0,1,0,8'h00);
    chk("restart instr_valid", 32'(s_valid), 32'd1);
    chk("restart instr_pc", 32'(s_pc), 32'd0);

    // Random ready/flush traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      step(1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom));
    end
    for (int n = 0; n < 6; n++) step(1'b0, 1'b1, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

endmodule
